shiftreg_ser_ctrl: RTL
======================

# shiftreg_ser_ctrl

Serializer controller that sequences a WIDTH-bit shift register. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per programmable bit period. It reports completion and supports abort. It sits between a word producer and a serial pin or link, and owns the load, shift-count and bit-timing decisions for the shift datapath.

## Interface
Parameters:
- WIDTH, 8: word length in bits; WIDTH ≥ 2.
- DIV_W, 8: width of the bit-period divisor.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  producer has a word on i_data.
- o_ready  out  1  controller can accept a word (registered).
- i_data  in  WIDTH  parallel word; captured only on accept.
- i_div  in  DIV_W  bit period minus 1, in clocks; captured only on accept.
- i_abort  in  1  abandon the current word.
- o_ser  out  1  serial data, MSB first (registered).
- o_bit_strobe  out  1  one-cycle pulse on the last cycle of each bit period.
- o_busy  out  1  a word is being shifted.
- o_done  out  1  one-cycle pulse after the last bit completes normally.

## Operation
- Reset values: state IDLE, o_ready=0, o_ser=0, o_bit_strobe=0, o_busy=0, o_done=0, shift register=0, counters=0.
- Reset is asserted asynchronously and released synchronously, i.e. the flops take effect on the first i_clk edge after release.
- o_ready rises to 1 on the first clock edge after reset release.
- States:
  - IDLE: o_ready=1, o_ser=0. Accept = i_valid & o_ready. On accept, load shreg←i_data, div_q←i_div, bit_cnt←WIDTH-1, tick_cnt←i_div, drop o_ready, go to SHIFT.
  - SHIFT: o_busy=1, o_ser=shreg[WIDTH-1]. tick_cnt decrements every clock.
    - When tick_cnt==0: o_bit_strobe=1 and tick_cnt←div_q.
    - If bit_cnt==0 on that strobe, go to DONE.
    - Otherwise shreg←{shreg[WIDTH-2:0],1'b0} and bit_cnt decrements.
  - DONE: o_done=1 for one cycle, o_ser=0, o_busy=0. Go to IDLE; o_ready=1 on the next cycle.
- i_abort in SHIFT:
  - Go to IDLE next cycle with o_ser=0 and o_ready=1.
  - No o_done and no o_bit_strobe on that cycle.
  - abort takes priority over strobe/terminal count.
- i_abort in IDLE or DONE: ignored.
- i_valid while not ready: ignored; i_data and i_div changes have no effect.
- i_div=0: one clock per bit. i_div=2^DIV_W-1: 2^DIV_W clocks per bit, with no wrap error.
- Simultaneous i_valid and i_abort in IDLE: the accept happens and the abort is ignored.

## Timing
- Accept at edge T, i.e. i_valid & o_ready sampled high at T.
- Bit k (k=0 is the MSB) is on o_ser during cycles T+1+k·(d+1) through T+(k+1)·(d+1), where d=i_div.
- o_bit_strobe is high in cycles T+(k+1)·(d+1).
- o_done is high in cycle T+WIDTH·(d+1)+1.
- o_ready is high again in cycle T+WIDTH·(d+1)+2.
- Minimum word-to-word spacing: WIDTH·(d+1)+2 cycles.
- Abort sampled at edge A: o_ser=0, o_busy=0 and o_ready=1 from cycle A+1.

## Structure
- Package shiftreg_pkg holds:
  - the state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the bit-count width function clog2(WIDTH).
- One sub-module, shift_tick: a DIV_W-bit down-counter with load/reload and a terminal pulse that produces o_bit_strobe.
- The FSM, shreg and bit_cnt live in the top.

## Test plan
- WIDTH=8, div=0, accept 0xA5 at T → o_ser = 1,0,1,0,0,1,0,1 over T+1..T+8; strobe every cycle; o_done at T+9; o_ready at T+10.
- div=2, data 0x81 → each bit held 3 cycles; strobes at T+3, T+6 … T+24; o_ser high at T+1..T+3 and T+22..T+24; o_done at T+25.
- Change i_valid, i_data and i_div while busy (0xFF, div=0 injected at T+4) → output stream of the first word unchanged; no second accept until o_ready.
- Assert i_abort at T+5 during 0xA5, div=0 → o_ser=0 and o_ready=1 at T+6; no o_done pulse; next word 0x3C shifts correctly.
- Pull i_rst_n low mid-word at T+4 → all outputs 0 immediately, without waiting for a clock; o_ready returns 1 one edge after release.
- div=255 with 0x01 → 256 cycles per bit; o_done at T+2049; no counter wrap.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared types and helpers for the shift-register serializer controller.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_tick.sv
// Bit-period down-counter: loads on word accept, reloads on terminal count while running.
module shift_tick #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_reload_val,
    output logic             o_zero
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_run) begin
            cnt_d = (cnt_q == '0) ? i_reload_val : cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/shiftreg_ser_ctrl.sv
// Serializer controller: accepts parallel words by valid/ready and shifts them out MSB-first
// with a programmable bit period, reporting completion and honouring abort.
module shiftreg_ser_ctrl
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_abort,
    output logic             o_ser,
    output logic             o_bit_strobe,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BCW = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ready_q, ready_d;
    logic             ser_q, ser_d;
    logic             tick_zero;
    logic             tick_load;
    logic             strobe;
    logic             busy;
    logic             done;

    shift_tick #(
        .DIV_W(DIV_W)
    ) u_tick (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (tick_load),
        .i_load_val  (i_div),
        .i_run       (state_q == SHIFT),
        .i_reload_val(div_q),
        .o_zero      (tick_zero)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        tick_load = 1'b0;
        strobe    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    shreg_d   = i_data;
                    div_d     = i_div;
                    bit_cnt_d = BCW'(WIDTH - 1);
                    tick_load = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                // Abort wins over the strobe and the terminal bit count.
                if (i_abort) begin
                    state_d = IDLE;
                end else if (tick_zero) begin
                    strobe = 1'b1;
                    if (bit_cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - BCW'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        ser_d   = (state_d == SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            ready_q   <= 1'b0;
            ser_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            ready_q   <= ready_d;
            ser_q     <= ser_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_ser        = ser_q;
    assign o_bit_strobe = strobe;
    assign o_busy       = busy;
    assign o_done       = done;

endmodule
